// File: rtl/order_injector_if.sv
// Host-side order write port for the order injector.
// Ports: wr_valid/wr_ready handshake, wr_side (0 buy, 1 sell), wr_price.
`timescale 1ns/1ps
interface order_injector_if;
    logic       wr_valid;
    logic       wr_ready;
    logic       wr_side;
    logic [5:0] wr_price;

    modport master (
        output wr_valid,
        output wr_side,
        output wr_price,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_side,
        input  wr_price,
        output wr_ready
    );
endinterface

// File: rtl/order_injector.sv
// Order injector: FIFO-buffered host orders serialised as one-cycle
// order book pulses with programmable idle spacing between pulses.
// Ports: clk, rst_n, wr (host write port), enable, flush, gap_cycles,
// input_type/data_in/ext_data (order book bus), fifo_level,
// sent_count, overflow.
`timescale 1ns/1ps
module order_injector #(
    parameter int DEPTH = 8,
    parameter int GAP_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    order_injector_if.slave        wr,
    input  logic                   enable,
    input  logic                   flush,
    input  logic [GAP_W-1:0]       gap_cycles,
    output logic [1:0]             input_type,
    output logic [5:0]             data_in,
    output logic [5:0]             ext_data,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [7:0]             sent_count,
    output logic                   overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_e;

    logic [6:0]       mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [LW-1:0]    count_q, count_d;
    state_e           state_q, state_d;
    logic [GAP_W-1:0] cnt_q, cnt_d;
    logic [1:0]       type_q, type_d;
    logic [5:0]       data_q, data_d;
    logic [5:0]       ext_q, ext_d;
    logic [7:0]       sent_q, sent_d;
    logic             ovf_q, ovf_d;

    logic       full;
    logic       empty;
    logic       push;
    logic       can_pop;
    logic       pop;
    logic [6:0] head;

    assign full        = (count_q == LW'(DEPTH));
    assign empty       = (count_q == '0);
    assign wr.wr_ready = !full;
    assign push        = wr.wr_valid && !full && !flush;
    assign can_pop     = enable && !empty && !flush;
    assign head        = mem_q[rptr_q];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (can_pop) begin
                    state_d = SEND;
                    pop     = 1'b1;
                end
            end
            SEND: begin
                if (gap_cycles != '0) begin
                    state_d = GAP;
                    cnt_d   = gap_cycles;
                end else if (can_pop) begin
                    pop = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (cnt_q == GAP_W'(1)) begin
                    if (can_pop) begin
                        state_d = SEND;
                        pop     = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_comb begin
        type_d  = 2'b00;
        data_d  = '0;
        ext_d   = '0;
        sent_d  = sent_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q | (wr.wr_valid && full);
        // head = {side, price[5:0]}
        if (pop) begin
            type_d = {1'b1, head[6]};
            data_d = {head[4:0], 1'b0};
            ext_d  = {5'b0, head[5]};
            sent_d = sent_q + 8'd1;
            rptr_d = rptr_q + AW'(1);
        end
        if (push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + LW'(1);
        end else if (pop && !push) begin
            count_d = count_q - LW'(1);
        end
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            type_q  <= 2'b00;
            data_q  <= '0;
            ext_q   <= '0;
            sent_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            type_q  <= type_d;
            data_q  <= data_d;
            ext_q   <= ext_d;
            sent_q  <= sent_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage needs no reset; count_q gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= {wr.wr_side, wr.wr_price};
        end
    end

    assign input_type = type_q;
    assign data_in    = data_q;
    assign ext_data   = ext_q;
    assign fifo_level = count_q;
    assign sent_count = sent_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_order_injector.sv
// Scoreboard bench for order_injector: directed scenarios plus a
// randomized phase checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_order_injector;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable;
    logic       flush;
    logic [3:0] gap;
    logic [1:0] input_type;
    logic [5:0] data_in;
    logic [5:0] ext_data;
    logic [3:0] fifo_level;
    logic [7:0] sent_count;
    logic       overflow;

    always #5 clk = ~clk;

    order_injector_if wr_if ();

    order_injector #(
        .DEPTH(8),
        .GAP_W(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr        (wr_if),
        .enable    (enable),
        .flush     (flush),
        .gap_cycles(gap),
        .input_type(input_type),
        .data_in   (data_in),
        .ext_data  (ext_data),
        .fifo_level(fifo_level),
        .sent_count(sent_count),
        .overflow  (overflow)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulses = 0;
    int last_acc = 0;
    int ptimes[$];
    logic [13:0] exp_q[$];
    bit exp_ovf = 1'b0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Expected bus word {input_type, data_in, ext_data} for an order.
    function automatic logic [13:0] enc(bit side, int price);
        int t, d, e;
        t = side ? 3 : 2;
        d = (price % 32) * 2;
        e = price / 32;
        return {t[1:0], d[5:0], e[5:0]};
    endfunction

    always @(negedge clk) begin : monitor
        logic [13:0] e;
        if (rst_n) begin
            cyc++;
            if (input_type != 2'b00) begin
                pulses++;
                ptimes.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {input_type, data_in, ext_data}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse", {input_type, data_in, ext_data}, e);
                end
            end else begin
                chk("idle_bus", {data_in, ext_data}, 0);
            end
        end
    end

    task automatic cycles(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(bit side, logic [5:0] p, output bit acc);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_side  = side;
        wr_if.wr_price = p;
        @(negedge clk);
        acc = wr_if.wr_ready && !flush;
        @(posedge clk);
        #1;
        wr_if.wr_valid = 1'b0;
        last_acc = cyc + 1;
        if (acc) exp_q.push_back(enc(side, int'(p)));
        else exp_ovf = 1'b1;
    endtask

    task automatic wait_pulses(string nm, int target, int budget);
        for (int i = 0; i < budget && pulses < target; i++) begin
            @(posedge clk);
            #1;
        end
        chk(nm, pulses, target);
    endtask

    task automatic chk_gap(string nm, int idx, int want);
        if (ptimes.size() > idx && idx > 0)
            chk(nm, ptimes[idx] - ptimes[idx-1], want);
        else
            chk({nm, "_missing"}, ptimes.size(), idx + 1);
    endtask

    initial begin
        bit acc;
        int nacc;
        int base;
        int viol;
        int tgt;
        enable = 1'b0;
        flush  = 1'b0;
        gap    = 4'd0;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_side  = 1'b0;
        wr_if.wr_price = 6'd0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_type", input_type, 0);
        chk("rst_data", {data_in, ext_data}, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_sent", sent_count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_ready", wr_if.wr_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(1);

        // Single buy, latency and one-cycle width
        enable = 1'b1;
        push(1'b0, 6'h2A, acc);
        wait_pulses("t1_pulses", 1, 10);
        if (ptimes.size() > 0)
            chk("t1_latency", ptimes[0] - last_acc, 1);
        cycles(5);
        chk("t1_single", pulses, 1);
        chk("t1_sent", sent_count, 1);

        // Back-to-back sells
        enable = 1'b0;
        push(1'b1, 6'd5, acc);
        push(1'b1, 6'd6, acc);
        push(1'b1, 6'd7, acc);
        cycles(2);
        chk("t2_level3", fifo_level, 3);
        base = ptimes.size();
        enable = 1'b1;
        wait_pulses("t2_pulses", 4, 20);
        chk_gap("t2_gap_a", base + 1, 1);
        chk_gap("t2_gap_b", base + 2, 1);
        chk("t2_level0", fifo_level, 0);
        chk("t2_sent", sent_count, 4);

        // Gap of 3 idle cycles
        enable = 1'b0;
        gap = 4'd3;
        push(1'b0, 6'd10, acc);
        push(1'b0, 6'd20, acc);
        base = ptimes.size();
        enable = 1'b1;
        wait_pulses("t3_pulses", 6, 30);
        chk_gap("t3_gap", base + 1, 4);

        // Overflow
        enable = 1'b0;
        gap = 4'd0;
        cycles(2);
        nacc = 0;
        for (int i = 0; i < 9; i++) begin
            push(1'b0, 6'(i * 3 + 1), acc);
            if (acc) nacc++;
        end
        chk("t4_accepted", nacc, 8);
        chk("t4_ready", wr_if.wr_ready, 0);
        chk("t4_ovf", overflow, exp_ovf);
        chk("t4_level", fifo_level, 8);
        enable = 1'b1;
        wait_pulses("t4_pulses", 14, 40);
        cycles(5);
        chk("t4_no_ninth", pulses, 14);
        chk("t4_ovf_sticky", overflow, 1);
        chk("t4_level0", fifo_level, 0);

        // Flush during GAP
        enable = 1'b0;
        gap = 4'd5;
        for (int i = 0; i < 4; i++) push(1'b1, 6'($urandom_range(0, 63)), acc);
        enable = 1'b1;
        wait_pulses("t5_first", 15, 10);
        cycles(2);
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        exp_q.delete();
        chk("t5_level0", fifo_level, 0);
        chk("t5_idle", input_type, 0);
        cycles(12);
        chk("t5_no_more", pulses, 15);
        push(1'b0, 6'd33, acc);
        wait_pulses("t5_after", 16, 20);
        chk("t5_sent", sent_count, 16);
        chk("t5_ovf_kept", overflow, 1);

        // Reset during SEND
        gap = 4'd0;
        cycles(8);
        push(1'b1, 6'h3F, acc);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (input_type != 2'b00) break;
        end
        chk("t6_in_send", input_type, 3);
        rst_n = 1'b0;
        #1;
        chk("t6_type", input_type, 0);
        chk("t6_data", {data_in, ext_data}, 0);
        chk("t6_sent", sent_count, 0);
        chk("t6_ready", wr_if.wr_ready, 1);
        chk("t6_ovf", overflow, 0);
        exp_q.delete();
        ptimes.delete();
        pulses = 0;
        exp_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycles(1);
        push(1'b0, 6'd17, acc);
        wait_pulses("t6_after", 1, 10);
        chk("t6_sent_after", sent_count, 1);

        // Randomized traffic against the queue model, gap fixed at 2
        gap = 4'd2;
        cycles(4);
        base = ptimes.size();
        for (int i = 0; i < 300; i++) begin
            enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1)
                push(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), acc);
            else
                cycles(1);
        end
        enable = 1'b1;
        tgt = pulses + exp_q.size();
        wait_pulses("rnd_drain", tgt, 200);
        cycles(5);
        chk("rnd_q_empty", exp_q.size(), 0);
        chk("rnd_level", fifo_level, 0);
        chk("rnd_sent", sent_count, pulses % 256);
        chk("rnd_ovf", overflow, exp_ovf);
        viol = 0;
        for (int i = base + 1; i < ptimes.size(); i++)
            if (ptimes[i] - ptimes[i-1] < 3) viol++;
        chk("rnd_gap_min", viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/order_injector.md
Name: order_injector

Overview:
Transmit-side feeder for the order book input bus. Buffers buy/sell orders from a host-side valid/ready port in a small FIFO. Serialises them onto the order book's `input_type`/`data_in`/`ext_data` bus as one-cycle order pulses, with programmable idle spacing between pulses. Sits between the host command decoder and the order book engine, and reports sent-order count and overflow status.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2.
GAP_W, 4, width of `gap_cycles`.

Ports:
clk  in  1  clock; single clock domain.
rst_n  in  1  asynchronous active-low reset.
wr_valid  in  1  host presents an order.
wr_ready  out  1  FIFO can accept; equals !full (registered state only, no combinational path from `wr_valid`).
wr_side  in  1  0=buy, 1=sell.
wr_price  in  6  order price 0..63.
enable  in  1  permits new FIFO pops.
flush  in  1  synchronous clear of FIFO and sequencer.
gap_cycles  in  GAP_W  idle cycles forced between consecutive order pulses.
input_type  out  2  to order book: 00 idle, 10 buy, 11 sell; 01 never driven.
data_in  out  6  to order book: {price[4:0],1'b0}.
ext_data  out  6  to order book: {5'b0,price[5]}.
fifo_level  out  $clog2(DEPTH)+1  entries held.
sent_count  out  8  orders issued; wraps 255->0.
overflow  out  1  sticky; set when `wr_valid && !wr_ready`; cleared only by reset.

Behaviour:
- Reset: `input_type`=00, `data_in`=0, `ext_data`=0, `fifo_level`=0, `sent_count`=0, `overflow`=0, `wr_ready`=1, state IDLE. Reset mid-pulse or mid-gap aborts immediately; outputs go to 00/0 asynchronously.
- Push: on a clock edge where `wr_valid && wr_ready && !flush`, `{wr_side, wr_price}` is written at the tail. Full FIFO means `wr_ready`=0 and the write is dropped, setting `overflow`.
- Pop: head entry is loaded into the output registers at the edge the FSM enters SEND. `can_pop` = `enable && !empty && !flush`.
- A push and a pop on the same edge are both performed; level is unchanged.
- The FIFO has no fall-through. An order accepted at edge E appears on the bus no earlier than the cycle after edge E+1.
- All bus outputs are registered. Outside SEND: `input_type`=00, `data_in`=0, `ext_data`=0.
- FSM states IDLE, SEND, GAP:
  - IDLE: `can_pop` -> SEND (pop); otherwise stay.
  - SEND (exactly one cycle; bus shows the order; `sent_count` increments on entry). Sample `gap_cycles`=G.
    - G=0: `can_pop` -> SEND (back-to-back pulses); otherwise IDLE.
    - G>0: -> GAP with cnt=G.
  - GAP: bus idle; cnt decrements each cycle. When cnt==1: `can_pop` -> SEND, otherwise IDLE. GAP therefore lasts exactly G cycles.
- `enable` deassertion never truncates a SEND or a GAP; it only blocks the next pop.
- `flush` (priority over push and pop): at the edge, FIFO emptied, level=0, state IDLE, bus idle next cycle. `sent_count` and `overflow` are unaffected.
- `gap_cycles` changes take effect only at the next SEND exit.
- Pointers wrap modulo DEPTH. The count register distinguishes full from empty.

Test Plan:
- Reset, `enable`=1, G=0. Push buy 0x2A at edge E -> `input_type`=10, `data_in`=0x14, `ext_data`=0x01 for exactly one cycle after E+1; then 00; `sent_count`=1.
- G=0, push 3 sells (5, 6, 7) while `enable`=0, then raise `enable` -> three consecutive cycles of `input_type`=11 with `data_in`=0x0A, 0x0C, 0x0E; `fifo_level` 3->0.
- G=3, two queued buys -> pulse, exactly 3 idle cycles, pulse.
- `enable`=0, push 9 orders with DEPTH=8 -> `wr_ready`=0 after 8; `overflow`=1 and stays set; `fifo_level`=8; the 9th order is never issued.
- Queue 4, G=5, assert `flush` during GAP -> bus stays 00, `fifo_level`=0, IDLE; a subsequent push issues normally.
- Pulse `rst_n` low during SEND -> outputs 00/0 immediately, `sent_count`=0, `wr_ready`=1.
